// File: rtl/cook_cycle_sequencer.sv
// Microwave cook-cycle sequencer: BCD mm:ss countdown from a clock prescaler,
// button/door handling and power-level duty cycling of the magnetron enable.
module cook_cycle_sequencer #(
  parameter int TICKS_PER_SEC = 100,
  parameter int POWER_PERIOD  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        startn,
  input  logic        stopn,
  input  logic        clearn,
  input  logic        door_closed,
  input  logic        time_load,
  input  logic [15:0] time_in,
  input  logic [3:0]  power_in,
  output logic        mag_on,
  output logic        timer_done,
  output logic [15:0] time_left,
  output logic [2:0]  state
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int SW = (POWER_PERIOD > 1) ? $clog2(POWER_PERIOD) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t         state_reg;
  logic [15:0]    time_reg;
  logic [3:0]     power_reg;
  logic [PW-1:0]  presc_reg;
  logic [SW-1:0]  slot_reg;
  logic           timer_done_reg;
  logic           startn_q;
  logic           stopn_q;
  logic           door_q;

  logic           start_ev;
  logic           stop_ev;
  logic           door_fall;
  logic           tick;
  logic [3:0]     digit_ok;
  logic           time_valid;
  logic [15:0]    load_time;
  logic [3:0]     load_power;
  state_t         load_state;
  logic [15:0]    time_dec;
  logic [SW-1:0]  slot_inc;

  assign start_ev  = startn_q & ~startn;
  assign stop_ev   = stopn_q & ~stopn;
  assign door_fall = door_q & ~door_closed;
  assign tick      = (presc_reg == PW'(TICKS_PER_SEC - 1));

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign digit_ok[gi] = (time_in[4*gi +: 4] <= 4'd9);
  end

  assign time_valid = (&digit_ok) & (time_in[7:4] <= 4'd5);
  assign load_time  = time_valid ? time_in : time_reg;
  assign load_power = ((power_in == 4'd0) || (power_in > 4'd10)) ? 4'd10 : power_in;
  assign load_state = (load_time != 16'h0000) ? ST_READY : ST_IDLE;
  assign slot_inc   = (slot_reg == SW'(POWER_PERIOD - 1)) ? '0 : slot_reg + 1'b1;

  // BCD borrow chain; only evaluated while counting, so time_reg is never 00:00 here.
  always_comb begin
    time_dec = time_reg;
    if (time_reg[3:0] != 4'd0) begin
      time_dec[3:0] = time_reg[3:0] - 4'd1;
    end else begin
      time_dec[3:0] = 4'd9;
      if (time_reg[7:4] != 4'd0) begin
        time_dec[7:4] = time_reg[7:4] - 4'd1;
      end else begin
        time_dec[7:4] = 4'd5;
        if (time_reg[11:8] != 4'd0) begin
          time_dec[11:8] = time_reg[11:8] - 4'd1;
        end else begin
          time_dec[11:8]  = 4'd9;
          time_dec[15:12] = time_reg[15:12] - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      time_reg       <= 16'h0000;
      power_reg      <= 4'd10;
      presc_reg      <= '0;
      slot_reg       <= '0;
      timer_done_reg <= 1'b0;
      startn_q       <= 1'b1;
      stopn_q        <= 1'b1;
      door_q         <= 1'b0;
    end else begin
      startn_q       <= startn;
      stopn_q        <= stopn;
      door_q         <= door_closed;
      timer_done_reg <= 1'b0;
      if (!clearn) begin
        state_reg <= ST_IDLE;
        time_reg  <= 16'h0000;
        power_reg <= 4'd10;
        presc_reg <= '0;
        slot_reg  <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (time_load) begin
              time_reg  <= load_time;
              power_reg <= load_power;
              state_reg <= load_state;
            end
          end
          ST_READY: begin
            if (stop_ev) begin
              state_reg <= ST_IDLE;
              time_reg  <= 16'h0000;
            end else if (start_ev && door_closed) begin
              state_reg <= ST_COOK;
              presc_reg <= '0;
              slot_reg  <= '0;
            end else if (time_load) begin
              time_reg  <= load_time;
              power_reg <= load_power;
              state_reg <= load_state;
            end
          end
          ST_COOK: begin
            if (!door_closed || stop_ev) begin
              state_reg <= ST_PAUSE;
            end else if (tick) begin
              presc_reg <= '0;
              slot_reg  <= slot_inc;
              time_reg  <= time_dec;
              if (time_dec == 16'h0000) begin
                state_reg      <= ST_DONE;
                timer_done_reg <= 1'b1;
              end
            end else begin
              presc_reg <= presc_reg + 1'b1;
            end
          end
          ST_PAUSE: begin
            if (stop_ev) begin
              state_reg <= ST_IDLE;
              time_reg  <= 16'h0000;
            end else if (start_ev && door_closed) begin
              state_reg <= ST_COOK;
              presc_reg <= '0;
              slot_reg  <= '0;
            end
          end
          ST_DONE: begin
            time_reg <= 16'h0000;
            if (stop_ev || start_ev || door_fall) begin
              state_reg <= ST_IDLE;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Door term is taken straight from the pin so opening the door cuts power immediately.
  assign mag_on     = (state_reg == ST_COOK) & door_closed & (32'(slot_reg) < 32'(power_reg));
  assign timer_done = timer_done_reg;
  assign time_left  = time_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_cook_cycle_sequencer.sv
// Bench for cook_cycle_sequencer with a 4-cycle second and a 10-second power window.
module tb_cook_cycle_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        startn = 1'b1;
  logic        stopn = 1'b1;
  logic        clearn = 1'b1;
  logic        door_closed = 1'b1;
  logic        time_load = 1'b0;
  logic [15:0] time_in = 16'h0000;
  logic [3:0]  power_in = 4'd10;
  logic        mag_on;
  logic        timer_done;
  logic [15:0] time_left;
  logic [2:0]  state;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [15:0] exp_time_q[$];

  localparam logic [2:0] S_IDLE = 3'd0, S_READY = 3'd1, S_COOK = 3'd2,
                         S_PAUSE = 3'd3, S_DONE = 3'd4;

  cook_cycle_sequencer #(.TICKS_PER_SEC(4), .POWER_PERIOD(10)) dut (
    .clk(clk), .rst(rst), .startn(startn), .stopn(stopn), .clearn(clearn),
    .door_closed(door_closed), .time_load(time_load), .time_in(time_in),
    .power_in(power_in), .mag_on(mag_on), .timer_done(timer_done),
    .time_left(time_left), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [15:0] t, input logic [3:0] p);
    time_in = t; power_in = p; time_load = 1'b1;
    step(1);
    time_load = 1'b0;
  endtask

  task automatic press_start();
    startn = 1'b0; step(1); startn = 1'b1;
  endtask

  task automatic press_stop();
    stopn = 1'b0; step(1); stopn = 1'b1;
  endtask

  task automatic pulse_clear();
    clearn = 1'b0; step(1); clearn = 1'b1;
  endtask

  // Pops the scoreboard each time time_left moves; checks value, spacing and timer_done.
  task automatic watch_time(input int max_cycles, input int interval);
    logic [15:0] prev;
    logic [15:0] exp;
    int since;
    int cyc;
    prev = time_left; since = 0; cyc = 0;
    while (exp_time_q.size() != 0 && cyc < max_cycles) begin
      step(1); cyc++; since++;
      if (time_left !== prev) begin
        exp = exp_time_q.pop_front();
        total_cnt++;
        if (time_left !== exp) $display("FAIL countdown_value: got %h expected %h", time_left, exp);
        else pass_cnt++;
        total_cnt++;
        if (since !== interval) $display("FAIL tick_spacing: got %0d cycles expected %0d", since, interval);
        else pass_cnt++;
        total_cnt++;
        if (timer_done !== (exp == 16'h0000)) $display("FAIL timer_done_at_step: got %b expected %b", timer_done, (exp == 16'h0000));
        else pass_cnt++;
        prev = time_left; since = 0;
      end
    end
    if (exp_time_q.size() != 0) begin
      total_cnt++;
      $display("FAIL countdown_timeout: %0d expected updates never seen", exp_time_q.size());
      exp_time_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; step(2); rst = 1'b0; step(1);
    total_cnt++; if (state !== S_IDLE) $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE); else pass_cnt++;
    total_cnt++; if (time_left !== 16'h0000) $display("FAIL reset_time: got %h expected 0000", time_left); else pass_cnt++;
    total_cnt++; if (timer_done !== 1'b0) $display("FAIL reset_timer_done: got %b expected 0", timer_done); else pass_cnt++;
    total_cnt++; if (mag_on !== 1'b0) $display("FAIL reset_mag_on: got %b expected 0", mag_on); else pass_cnt++;
  endtask

  task automatic test_basic_countdown();
    door_closed = 1'b1;
    load(16'h0003, 4'd10);
    total_cnt++; if (state !== S_READY) $display("FAIL load_ready: got %0d expected %0d", state, S_READY); else pass_cnt++;
    press_start();
    total_cnt++; if (state !== S_COOK) $display("FAIL start_cook: got %0d expected %0d", state, S_COOK); else pass_cnt++;
    total_cnt++; if (mag_on !== 1'b1) $display("FAIL full_power_mag: got %b expected 1", mag_on); else pass_cnt++;
    exp_time_q.push_back(16'h0002);
    exp_time_q.push_back(16'h0001);
    exp_time_q.push_back(16'h0000);
    watch_time(20, 4);
    total_cnt++; if (state !== S_DONE) $display("FAIL done_state: got %0d expected %0d", state, S_DONE); else pass_cnt++;
    total_cnt++; if (mag_on !== 1'b0) $display("FAIL done_mag_off: got %b expected 0", mag_on); else pass_cnt++;
    step(1);
    total_cnt++; if (timer_done !== 1'b0) $display("FAIL timer_done_width: got %b expected 0", timer_done); else pass_cnt++;
    load(16'h0005, 4'd10);
    total_cnt++; if (time_left !== 16'h0000) $display("FAIL done_ignores_load: got %h expected 0000", time_left); else pass_cnt++;
    press_start();
    total_cnt++; if (state !== S_IDLE) $display("FAIL done_exit: got %0d expected %0d", state, S_IDLE); else pass_cnt++;
  endtask

  task automatic test_bcd_borrow();
    load(16'h0100, 4'd10);
    press_start();
    exp_time_q.push_back(16'h0059);
    watch_time(10, 4);
    press_stop();
    total_cnt++; if (state !== S_PAUSE) $display("FAIL stop_pause: got %0d expected %0d", state, S_PAUSE); else pass_cnt++;
    step(1);
    press_stop();
    total_cnt++; if (state !== S_IDLE || time_left !== 16'h0000) $display("FAIL stop_idle: got %0d/%h expected %0d/0000", state, time_left, S_IDLE); else pass_cnt++;
    load(16'h1000, 4'd10);
    press_start();
    exp_time_q.push_back(16'h0959);
    watch_time(10, 4);
    pulse_clear();
  endtask

  task automatic test_invalid_load();
    load(16'h0005, 4'd10);
    load(16'h0070, 4'd10);
    total_cnt++; if (time_left !== 16'h0005 || state !== S_READY) $display("FAIL invalid_sec_tens: got %h/%0d expected 0005/%0d", time_left, state, S_READY); else pass_cnt++;
    load(16'h0A00, 4'd10);
    total_cnt++; if (time_left !== 16'h0005) $display("FAIL invalid_digit: got %h expected 0005", time_left); else pass_cnt++;
    press_start();
    load(16'h0001, 4'd10);
    total_cnt++; if (time_left !== 16'h0005 || state !== S_COOK) $display("FAIL cook_ignores_load: got %h/%0d expected 0005/%0d", time_left, state, S_COOK); else pass_cnt++;
    pulse_clear();
    total_cnt++; if (state !== S_IDLE || time_left !== 16'h0000 || mag_on !== 1'b0) $display("FAIL clear_cook: got %0d/%h/%b expected 0/0000/0", state, time_left, mag_on); else pass_cnt++;
  endtask

  task automatic test_power_duty();
    load(16'h0020, 4'd3);
    press_start();
    for (int k = 0; k < 40; k++) begin
      total_cnt++;
      if (mag_on !== (((k / 4) % 10) < 3)) $display("FAIL duty_k%0d: got %b expected %b", k, mag_on, (((k / 4) % 10) < 3));
      else pass_cnt++;
      step(1);
    end
    step(6);
    press_stop();
    total_cnt++; if (state !== S_PAUSE || time_left !== 16'h0009) $display("FAIL duty_pause: got %0d/%h expected %0d/0009", state, time_left, S_PAUSE); else pass_cnt++;
    step(5);
    press_start();
    for (int k = 0; k < 16; k++) begin
      total_cnt++;
      if (mag_on !== (((k / 4) % 10) < 3)) $display("FAIL duty_resume_k%0d: got %b expected %b", k, mag_on, (((k / 4) % 10) < 3));
      else pass_cnt++;
      step(1);
    end
    total_cnt++; if (time_left !== 16'h0005) $display("FAIL duty_resume_time: got %h expected 0005", time_left); else pass_cnt++;
    pulse_clear();
  endtask

  task automatic test_door_pause();
    load(16'h0030, 4'd10);
    press_start();
    step(6);
    door_closed = 1'b0;
    #1;
    total_cnt++; if (mag_on !== 1'b0 || state !== S_COOK) $display("FAIL door_mag_same_cycle: got %b/%0d expected 0/%0d", mag_on, state, S_COOK); else pass_cnt++;
    step(1);
    total_cnt++; if (state !== S_PAUSE) $display("FAIL door_pause: got %0d expected %0d", state, S_PAUSE); else pass_cnt++;
    step(20);
    total_cnt++; if (time_left !== 16'h0029 || state !== S_PAUSE) $display("FAIL pause_frozen: got %h/%0d expected 0029/%0d", time_left, state, S_PAUSE); else pass_cnt++;
    door_closed = 1'b1;
    step(1);
    press_start();
    total_cnt++; if (state !== S_COOK || time_left !== 16'h0029 || mag_on !== 1'b1) $display("FAIL door_resume: got %0d/%h/%b expected %0d/0029/1", state, time_left, mag_on, S_COOK); else pass_cnt++;
    exp_time_q.push_back(16'h0028);
    watch_time(10, 4);
    pulse_clear();
  endtask

  task automatic test_held_buttons();
    load(16'h0010, 4'd10);
    startn = 1'b0;
    step(1);
    total_cnt++; if (state !== S_COOK) $display("FAIL held_start_enter: got %0d expected %0d", state, S_COOK); else pass_cnt++;
    step(9);
    total_cnt++; if (state !== S_COOK || time_left !== 16'h0008) $display("FAIL held_start_single: got %0d/%h expected %0d/0008", state, time_left, S_COOK); else pass_cnt++;
    startn = 1'b1;
    stopn = 1'b0;
    step(10);
    total_cnt++; if (state !== S_PAUSE || time_left !== 16'h0008) $display("FAIL held_stop_single: got %0d/%h expected %0d/0008", state, time_left, S_PAUSE); else pass_cnt++;
    stopn = 1'b1;
    step(1);
    press_stop();
    total_cnt++; if (state !== S_IDLE || time_left !== 16'h0000) $display("FAIL second_stop: got %0d/%h expected %0d/0000", state, time_left, S_IDLE); else pass_cnt++;
  endtask

  task automatic test_reset_held_start();
    load(16'h0005, 4'd3);
    press_start();
    step(2);
    total_cnt++; if (mag_on !== 1'b1) $display("FAIL pre_reset_mag: got %b expected 1", mag_on); else pass_cnt++;
    startn = 1'b0;
    rst = 1'b1;
    step(1);
    total_cnt++; if (state !== S_IDLE || mag_on !== 1'b0 || time_left !== 16'h0000) $display("FAIL reset_mid_cook: got %0d/%b/%h expected 0/0/0000", state, mag_on, time_left); else pass_cnt++;
    step(1);
    rst = 1'b0;
    step(1);
    load(16'h0004, 4'd10);
    step(3);
    total_cnt++; if (state !== S_READY) $display("FAIL held_after_reset: got %0d expected %0d", state, S_READY); else pass_cnt++;
    startn = 1'b1;
    step(1);
    total_cnt++; if (state !== S_READY) $display("FAIL release_no_event: got %0d expected %0d", state, S_READY); else pass_cnt++;
    press_start();
    total_cnt++; if (state !== S_COOK) $display("FAIL repress_cook: got %0d expected %0d", state, S_COOK); else pass_cnt++;
    pulse_clear();
  endtask

  initial begin
    test_reset();
    test_basic_countdown();
    test_bcd_borrow();
    test_invalid_load();
    test_power_duty();
    test_door_pause();
    test_held_buttons();
    test_reset_held_start();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cook_cycle_sequencer.md
Name: cook_cycle_sequencer

Overview:
Top-level cook-cycle sequencer for the microwave controller. It holds the cook time as BCD mm:ss and counts it down once per second from a clock prescaler. It accepts user buttons (start/stop/clear) and the door sensor, and drives the magnetron enable with a power-level duty cycle. It generates the timer_done event the magnetron control path consumes, and it replaces free-running external timer logic.

Parameters:
TICKS_PER_SEC, 100, clk cycles per one-second tick (>=2); bench uses 4
POWER_PERIOD, 10, seconds per duty-cycle window; power level N = magnetron on N of every POWER_PERIOD seconds

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
startn  input  1  start button, active-low, synchronous level
stopn  input  1  stop button, active-low, synchronous level
clearn  input  1  clear button, active-low, synchronous level
door_closed  input  1  1 = door closed
time_load  input  1  load time_in/power_in this cycle
time_in  input  16  BCD {min_tens, min_ones, sec_tens, sec_ones}
power_in  input  4  power level 1..10
mag_on  output  1  magnetron enable
timer_done  output  1  one-cycle pulse when countdown reaches 00:00
time_left  output  16  remaining time, BCD mm:ss
state  output  3  IDLE=0, READY=1, COOK=2, PAUSE=3, DONE=4

Behaviour:
- Reset (rst=1 on a clock edge): state=IDLE, time_left=0x0000, power=10, prescaler=0, slot=0, timer_done=0, start/stop edge registers=1 (released). rst overrides everything.
- Button edges: start_ev = startn_q & ~startn. stop_ev is derived from stopn the same way. startn_q and stopn_q are registered copies. A held button produces exactly one event.
- clearn=0 (level), any state: next state IDLE, time_left=0, power=10, prescaler=0, slot=0.
- Priority per cycle: rst > clearn > door open > stop_ev > start_ev > time_load > tick.
- Load (IDLE/READY only; ignored in COOK/PAUSE/DONE):
  - time_in is accepted only if every digit is <=9 and sec_tens <=5; otherwise time_left is unchanged.
  - power_in 0 or >10 loads as 10.
  - Next state is READY if the loaded time is nonzero, else IDLE.
- IDLE: waits for a load; start_ev is ignored.
- READY:
  - start_ev with door_closed=1 -> COOK, prescaler=0, slot=0. start_ev with the door open is ignored.
  - stop_ev -> IDLE, time_left=0.
- COOK:
  - Prescaler counts 0..TICKS_PER_SEC-1. The tick is the cycle where prescaler == TICKS_PER_SEC-1.
  - On tick, time_left decrements in BCD:
    - ones borrow 0 -> 9;
    - sec 00 -> 59 with a minute borrow;
    - minute digits borrow likewise.
  - On tick, slot increments mod POWER_PERIOD.
  - On the tick where time_left goes 00:01 -> 00:00: next state DONE; timer_done=1 for exactly that following cycle.
  - door_closed=0 -> PAUSE. stop_ev -> PAUSE. start_ev is ignored.
- PAUSE:
  - Prescaler, slot and time_left are frozen.
  - start_ev with the door closed -> COOK, prescaler=0, slot=0.
  - stop_ev -> IDLE, time_left=0.
- DONE:
  - time_left=0000.
  - stop_ev, start_ev or door_closed 1->0 -> IDLE. Load is ignored until then.
- mag_on is combinational: (state==COOK) & door_closed & (slot < power). Opening the door drops mag_on in the same cycle, before the state register updates. mag_on=0 in all other states and during reset.
- A simultaneous start_ev and stop_ev resolves to stop.
- Reset mid-COOK forces mag_on=0 from the edge where rst is sampled.

Test Plan:
- TICKS_PER_SEC=4, rst, then load time_in=0x0003 with power 10, door closed, startn pulse -> state COOK next cycle. mag_on=1 continuously. time_left 0003->0002->0001->0000 every 4 cycles. timer_done high exactly 1 cycle, state DONE, mag_on 0.
- Load 0x0100, start, run 1 tick -> time_left=0x0059. Load 0x1000 and count through the borrow -> 0x0959. Load 0x0070 (invalid) -> time_left unchanged, state unchanged.
- Power 3, time 0x0020, POWER_PERIOD=10 -> mag_on high for 12 cycles, low for 28, repeating. Pattern restarts with slot=0 after a pause/resume.
- During COOK, drop door_closed -> mag_on 0 in the same cycle, state PAUSE next. time_left frozen for 20 cycles. Close door, startn pulse -> resumes from the same value.
- Hold startn low 10 cycles in READY -> single transition to COOK. Hold stopn low -> single PAUSE; second stopn press -> IDLE, time_left 0000.
- clearn low mid-COOK -> IDLE, time 0000, mag_on 0. Assert rst with startn held low -> no COOK entry after rst release until startn is released and pressed again.
